// File: rtl/edge_aggr_pe.sv
// Edge-aggregation PE: fetches a node's neighbor list, then streams neighbor FVs to the bank.
// Optional GCN self-loop fetch of the target node FV is enabled by EDGE_AGGR_SELF_LOOP_EN.
module edge_aggr_pe #(
    parameter int PE_TAG  = 0,
    parameter int NODE_W  = 7,
    parameter int FV_W    = 8,
    parameter int LANES   = 2,
    parameter int MAX_DEG = 16,
    parameter int ITER_W  = 4,
    localparam int CI_W   = $clog2(ITER_W),
    localparam int CNT_W  = $clog2(MAX_DEG + 1),
    localparam int TAG_W  = $clog2(PE_TAG + 2),
    localparam int DW     = LANES * FV_W,
    localparam int PKT_W  = 2 + ITER_W + 3 + NODE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    task_valid,
    output logic                    task_ready,
    input  logic [NODE_W-1:0]       task_node,
    input  logic [2:0]              task_prio,
    input  logic [ITER_W-1:0]       task_mask,
    input  logic [CI_W-1:0]         cur_iter,
    output logic                    arb_req,
    output logic                    arb_type,
    output logic [NODE_W-1:0]       arb_node,
    output logic [TAG_W-1:0]        arb_tag,
    input  logic                    arb_grant,
    input  logic                    nid_sos,
    input  logic                    nid_eos,
    input  logic [LANES*NODE_W-1:0] nid_data,
    input  logic [CNT_W-1:0]        nid_count,
    input  logic                    fv_sos,
    input  logic                    fv_eos,
    input  logic [DW-1:0]           fv_data,
    output logic                    out_req,
    input  logic                    out_grant,
    input  logic                    out_sos,
    input  logic                    out_eos,
    input  logic [DW-1:0]           out_data,
    output logic                    bank_valid,
    output logic                    bank_sos,
    output logic                    bank_eos,
    output logic                    bank_done,
    output logic                    bank_wb_en,
    output logic [NODE_W-1:0]       bank_node,
    output logic [DW-1:0]           bank_data,
    output logic                    wb_req,
    input  logic                    wb_grant,
    output logic [PKT_W-1:0]        wb_packet,
    output logic                    ovf_err
);

    localparam int AW = $clog2(MAX_DEG);
    localparam logic [CNT_W-1:0] DEG_MAX = CNT_W'(MAX_DEG);
    localparam logic [CNT_W-1:0] LANE_C  = CNT_W'(LANES);
`ifdef EDGE_AGGR_SELF_LOOP_EN
    localparam bit SELF_LOOP = 1'b1;
`else
    localparam bit SELF_LOOP = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, REQ_NID, WAIT_NID, STRM_NID, REQ_FV,
        WAIT_FV, STRM_FV, REQ_PRE, STRM_PRE, COMPLETE
    } state_t;

    state_t state, state_next;

    logic [NODE_W-1:0] buffer [MAX_DEG];
    logic [NODE_W-1:0] node_q;
    logic [2:0]        prio_q;
    logic [ITER_W-1:0] mask_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fv_ptr;
    logic              self_done;
    logic              pre_act;

    logic              need_pre;
    logic              need_wb;
    logic [CNT_W-1:0]  cnt_in;
    logic [CNT_W-1:0]  cnt_eff;
    logic              more_fv;
    state_t            post_state;
    logic              nid_beat;
    logic              fv_beat;
    logic              pre_beat;
    logic              leave_fv;
    logic [NODE_W-1:0] fv_node;

    always_comb begin
        need_pre = 1'b0;
        need_wb  = 1'b0;
        for (int i = 0; i < ITER_W; i++) begin
            if (mask_q[i] && i < int'(cur_iter)) need_pre = 1'b1;
            if (mask_q[i] && i > int'(cur_iter)) need_wb  = 1'b1;
        end
    end

    // A same-beat sos/eos must decide on the incoming count, not the stale one.
    assign cnt_in  = (nid_count > DEG_MAX) ? DEG_MAX : nid_count;
    assign cnt_eff = (state == WAIT_NID) ? cnt_in : count_q;
    assign more_fv = (fv_ptr < cnt_eff) || (SELF_LOOP && !self_done);

    assign post_state = more_fv  ? REQ_FV  :
                        need_pre ? REQ_PRE : COMPLETE;

    assign nid_beat = (state == WAIT_NID && nid_sos) || state == STRM_NID;
    assign fv_beat  = (state == WAIT_FV && fv_sos) || state == STRM_FV;
    assign pre_beat = state == STRM_PRE && (out_sos || pre_act);
    assign leave_fv = state_next == REQ_PRE || state_next == COMPLETE;

    assign fv_node = (fv_ptr < count_q) ? buffer[fv_ptr[AW-1:0]] : node_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (task_valid) state_next = REQ_NID;
            REQ_NID:  if (arb_grant) state_next = WAIT_NID;
            WAIT_NID: begin
                if (nid_sos) state_next = nid_eos ? post_state : STRM_NID;
            end
            STRM_NID: if (nid_eos) state_next = post_state;
            REQ_FV:   if (arb_grant) state_next = WAIT_FV;
            WAIT_FV: begin
                if (fv_sos) state_next = fv_eos ? post_state : STRM_FV;
            end
            STRM_FV:  if (fv_eos) state_next = post_state;
            REQ_PRE:  if (out_grant) state_next = STRM_PRE;
            STRM_PRE: if (pre_beat && out_eos) state_next = COMPLETE;
            COMPLETE: if (!need_wb || wb_grant) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign task_ready = state == IDLE;
    assign arb_req    = state == REQ_NID || state == REQ_FV;
    assign arb_type   = state == REQ_FV;
    assign arb_node   = (state == REQ_NID) ? node_q :
                        (state == REQ_FV)  ? fv_node : '0;
    assign arb_tag    = arb_req ? TAG_W'(PE_TAG) : '0;
    assign out_req    = state == REQ_PRE;
    assign wb_req     = state == COMPLETE && need_wb;
    assign wb_packet  = wb_req ? {2'b00, mask_q, prio_q, node_q} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            buffer     <= '{default: '0};
            node_q     <= '0;
            prio_q     <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            wr_ptr     <= '0;
            fv_ptr     <= '0;
            self_done  <= 1'b0;
            pre_act    <= 1'b0;
            ovf_err    <= 1'b0;
            bank_valid <= 1'b0;
            bank_sos   <= 1'b0;
            bank_eos   <= 1'b0;
            bank_done  <= 1'b0;
            bank_wb_en <= 1'b0;
            bank_node  <= '0;
            bank_data  <= '0;
        end else begin
            state      <= state_next;
            bank_valid <= 1'b0;
            bank_sos   <= 1'b0;
            bank_eos   <= 1'b0;
            bank_done  <= 1'b0;
            bank_wb_en <= 1'b0;
            bank_node  <= '0;
            bank_data  <= '0;

            if (state == IDLE && task_valid) begin
                node_q <= task_node;
                prio_q <= task_prio;
                mask_q <= task_mask;
            end

            // wr_ptr saturates at MAX_DEG so excess IDs are dropped.
            if (nid_beat) begin
                if (wr_ptr < DEG_MAX) begin
                    for (int l = 0; l < LANES; l++)
                        buffer[wr_ptr[AW-1:0] + AW'(l)] <=
                            nid_data[l*NODE_W +: NODE_W];
                    wr_ptr <= wr_ptr + LANE_C;
                end
                if (state == WAIT_NID) begin
                    count_q <= cnt_in;
                    if (nid_count > DEG_MAX) ovf_err <= 1'b1;
                end
                if (nid_eos) wr_ptr <= '0;
            end

            if (state == REQ_FV && arb_grant) begin
                if (fv_ptr < count_q) fv_ptr <= fv_ptr + 1'b1;
                else                  self_done <= 1'b1;
            end
            if (leave_fv) begin
                fv_ptr    <= '0;
                self_done <= 1'b0;
            end

            if (fv_beat) begin
                bank_valid <= 1'b1;
                bank_sos   <= fv_sos;
                bank_eos   <= fv_eos;
                bank_node  <= node_q;
                bank_data  <= fv_data;
            end

            if (pre_beat) begin
                bank_valid <= 1'b1;
                bank_sos   <= out_sos;
                bank_eos   <= out_eos;
                bank_node  <= node_q;
                bank_data  <= out_data;
                pre_act    <= !out_eos;
            end

            if (state == COMPLETE) begin
                if (!need_wb) begin
                    bank_valid <= 1'b1;
                    bank_done  <= 1'b1;
                    bank_node  <= node_q;
                end else if (wb_grant) begin
                    bank_valid <= 1'b1;
                    bank_wb_en <= 1'b1;
                    bank_node  <= node_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_aggr_pe.sv
// Scoreboard bench for edge_aggr_pe: expected bank beats are queued as stimulus is driven.
// Self-loop expectations follow EDGE_AGGR_SELF_LOOP_EN.
module tb_edge_aggr_pe;

    logic        clk;
    logic        reset;
    logic        task_valid;
    logic        task_ready;
    logic [6:0]  task_node;
    logic [2:0]  task_prio;
    logic [3:0]  task_mask;
    logic [1:0]  cur_iter;
    logic        arb_req;
    logic        arb_type;
    logic [6:0]  arb_node;
    logic [0:0]  arb_tag;
    logic        arb_grant;
    logic        nid_sos;
    logic        nid_eos;
    logic [13:0] nid_data;
    logic [4:0]  nid_count;
    logic        fv_sos;
    logic        fv_eos;
    logic [15:0] fv_data;
    logic        out_req;
    logic        out_grant;
    logic        out_sos;
    logic        out_eos;
    logic [15:0] out_data;
    logic        bank_valid;
    logic        bank_sos;
    logic        bank_eos;
    logic        bank_done;
    logic        bank_wb_en;
    logic [6:0]  bank_node;
    logic [15:0] bank_data;
    logic        wb_req;
    logic        wb_grant;
    logic [15:0] wb_packet;
    logic        ovf_err;

    edge_aggr_pe dut (
        .clk(clk), .reset(reset),
        .task_valid(task_valid), .task_ready(task_ready),
        .task_node(task_node), .task_prio(task_prio),
        .task_mask(task_mask), .cur_iter(cur_iter),
        .arb_req(arb_req), .arb_type(arb_type),
        .arb_node(arb_node), .arb_tag(arb_tag),
        .arb_grant(arb_grant),
        .nid_sos(nid_sos), .nid_eos(nid_eos),
        .nid_data(nid_data), .nid_count(nid_count),
        .fv_sos(fv_sos), .fv_eos(fv_eos), .fv_data(fv_data),
        .out_req(out_req), .out_grant(out_grant),
        .out_sos(out_sos), .out_eos(out_eos), .out_data(out_data),
        .bank_valid(bank_valid), .bank_sos(bank_sos),
        .bank_eos(bank_eos), .bank_done(bank_done),
        .bank_wb_en(bank_wb_en), .bank_node(bank_node),
        .bank_data(bank_data),
        .wb_req(wb_req), .wb_grant(wb_grant),
        .wb_packet(wb_packet), .ovf_err(ovf_err)
    );

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];
    logic [6:0]  cur_node;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] bt(input logic s, input logic e,
                                       input logic d, input logic w,
                                       input logic [6:0] n,
                                       input logic [15:0] dt);
        return {s, e, d, w, n, dt};
    endfunction

    function automatic logic [15:0] fvd(input int node, input int b);
        return {8'(node + b * 3), 8'(node ^ 8'h5A)};
    endfunction

    always @(negedge clk) begin
        if (bank_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("bank_extra", {bank_sos, bank_eos, bank_done,
                    bank_wb_en, bank_node, bank_data}, 0);
            else
                chk("bank", {bank_sos, bank_eos, bank_done, bank_wb_en,
                    bank_node, bank_data}, exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_task(input logic [6:0] n, input logic [2:0] p,
                              input logic [3:0] m, input logic [1:0] it,
                              input string tag);
        cur_node = n;
        chk({tag, "_rdy"}, task_ready, 1);
        task_valid = 1'b1;
        task_node  = n;
        task_prio  = p;
        task_mask  = m;
        cur_iter   = it;
        @(negedge clk);
        task_valid = 1'b0;
        chk({tag, "_lat"}, arb_req, 1);
    endtask

    task automatic grant_arb(input logic typ, input logic [6:0] node,
                             input string tag);
        int n = 0;
        while (arb_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, arb_req, 1);
        chk({tag, "_type"}, arb_type, typ);
        chk({tag, "_node"}, arb_node, node);
        arb_grant = 1'b1;
        @(negedge clk);
        arb_grant = 1'b0;
        chk({tag, "_drop"}, arb_req, 0);
    endtask

    task automatic send_nid(input int n, input int base,
                            input logic [4:0] cnt);
        int beats = (n == 0) ? 1 : (n + 1) / 2;
        for (int b = 0; b < beats; b++) begin
            nid_sos   = (b == 0);
            nid_eos   = (b == beats - 1);
            nid_count = cnt;
            nid_data  = {7'(base + 2 * b + 1), 7'(base + 2 * b)};
            @(negedge clk);
        end
        nid_sos = 1'b0;
        nid_eos = 1'b0;
    endtask

    task automatic send_fv(input int node, input int beats);
        for (int b = 0; b < beats; b++) begin
            fv_sos  = (b == 0);
            fv_eos  = (b == beats - 1);
            fv_data = fvd(node, b);
            exp_q.push_back(bt(fv_sos, fv_eos, 0, 0, cur_node, fv_data));
            @(negedge clk);
        end
        fv_sos = 1'b0;
        fv_eos = 1'b0;
    endtask

    task automatic fv_phase(input int k, input int base, input int beats);
        for (int i = 0; i < k; i++) begin
            grant_arb(1'b1, 7'(base + i), "fv");
            send_fv(base + i, beats);
        end
`ifdef EDGE_AGGR_SELF_LOOP_EN
        grant_arb(1'b1, cur_node, "self");
        send_fv(int'(cur_node), 1);
`endif
    endtask

    task automatic finish_wait(input string tag, output bit saw_arb,
                               output bit saw_wb, output bit saw_out);
        int n = 0;
        saw_arb = 0;
        saw_wb  = 0;
        saw_out = 0;
        while (!(task_ready === 1'b1 && exp_q.size() == 0) && n < 40) begin
            if (arb_req) saw_arb = 1;
            if (wb_req)  saw_wb  = 1;
            if (out_req) saw_out = 1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, task_ready, 1);
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        bit sa, sw, so;
        int n;
        reset = 1'b1;
        task_valid = 0; task_node = 0; task_prio = 0; task_mask = 0;
        cur_iter = 0; arb_grant = 0;
        nid_sos = 0; nid_eos = 0; nid_data = 0; nid_count = 0;
        fv_sos = 0; fv_eos = 0; fv_data = 0;
        out_grant = 0; out_sos = 0; out_eos = 0; out_data = 0;
        wb_grant = 0;
        cur_node = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", task_ready, 1);
        chk("rst_arb", {arb_req, arb_type, arb_node, arb_tag}, 0);
        chk("rst_out", out_req, 0);
        chk("rst_wb", {wb_req, wb_packet}, 0);
        chk("rst_bank", {bank_valid, bank_done, bank_wb_en}, 0);
        chk("rst_ovf", ovf_err, 0);

        // stray grant in IDLE is ignored
        arb_grant = 1'b1;
        @(negedge clk);
        arb_grant = 1'b0;
        chk("stray_grant", task_ready, 1);

        // basic: node 5, neighbors {1,2,3}
        start_task(7'd5, 3'd1, 4'b0000, 2'd0, "t1");
        chk("t1_tag", arb_tag, 0);
        grant_arb(1'b0, 7'd5, "t1_nid");
        send_nid(3, 1, 5'd3);
        fv_phase(3, 1, 1);
        exp_q.push_back(bt(0, 0, 1, 0, 7'd5, 0));
        finish_wait("t1", sa, sw, so);
        chk("t1_no_wb_out", {sw, so}, 0);
        chk("t1_ovf", ovf_err, 0);

        // zero-degree node
        start_task(7'd5, 3'd2, 4'b0000, 2'd0, "t2");
        grant_arb(1'b0, 7'd5, "t2_nid");
        send_nid(0, 0, 5'd0);
        fv_phase(0, 0, 1);
        exp_q.push_back(bt(0, 0, 1, 0, 7'd5, 0));
        finish_wait("t2", sa, sw, so);
        chk("t2_no_arb", sa, 0);

        // pre-output stream
        start_task(7'd33, 3'd4, 4'b0011, 2'd1, "t3");
        grant_arb(1'b0, 7'd33, "t3_nid");
        send_nid(1, 9, 5'd1);
        fv_phase(1, 9, 1);
        n = 0;
        while (out_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_out_req", out_req, 1);
        chk("t3_wb", wb_req, 0);
        out_grant = 1'b1;
        @(negedge clk);
        out_grant = 1'b0;
        chk("t3_out_drop", out_req, 0);
        @(negedge clk);
        out_sos = 1'b1; out_data = 16'hA1B2;
        exp_q.push_back(bt(1, 0, 0, 0, 7'd33, 16'hA1B2));
        @(negedge clk);
        out_sos = 1'b0; out_eos = 1'b1; out_data = 16'hC3D4;
        exp_q.push_back(bt(0, 1, 0, 0, 7'd33, 16'hC3D4));
        @(negedge clk);
        out_eos = 1'b0; out_data = 0;
        exp_q.push_back(bt(0, 0, 1, 0, 7'd33, 0));
        finish_wait("t3", sa, sw, so);
        chk("t3_no_wb", sw, 0);

        // write-back with delayed grant
        start_task(7'h2A, 3'd6, 4'b0100, 2'd1, "t4");
        grant_arb(1'b0, 7'h2A, "t4_nid");
        send_nid(1, 12, 5'd1);
        fv_phase(1, 12, 2);
        n = 0;
        while (wb_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_wb_req", wb_req, 1);
        chk("t4_pkt", wb_packet, {2'b00, 4'b0100, 3'd6, 7'h2A});
        chk("t4_no_out", out_req, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold", {wb_req, task_ready}, 2'b10);
        end
        wb_grant = 1'b1;
        exp_q.push_back(bt(0, 0, 0, 1, 7'h2A, 0));
        @(negedge clk);
        wb_grant = 1'b0;
        chk("t4_wb_drop", wb_req, 0);
        finish_wait("t4", sa, sw, so);

        // overflow: 20 IDs, 16 kept
        start_task(7'd64, 3'd0, 4'b0000, 2'd0, "t5");
        grant_arb(1'b0, 7'd64, "t5_nid");
        send_nid(20, 20, 5'd20);
        chk("t5_ovf", ovf_err, 1);
        fv_phase(16, 20, 1);
        exp_q.push_back(bt(0, 0, 1, 0, 7'd64, 0));
        finish_wait("t5", sa, sw, so);
        chk("t5_exact16", sa, 0);
        chk("t5_sticky", ovf_err, 1);

        // reset during STRM_FV
        start_task(7'h11, 3'd0, 4'b0000, 2'd0, "t6");
        grant_arb(1'b0, 7'h11, "t6_nid");
        send_nid(1, 7, 5'd1);
        grant_arb(1'b1, 7'd7, "t6_fv");
        fv_sos = 1'b1; fv_data = 16'h1357;
        exp_q.push_back(bt(1, 0, 0, 0, 7'h11, 16'h1357));
        @(negedge clk);
        fv_sos = 1'b0; fv_data = 16'h2468;
        reset = 1'b1;
        @(negedge clk);
        fv_data = 0;
        chk("t6_idle", task_ready, 1);
        chk("t6_bank", {bank_valid, bank_data}, 0);
        chk("t6_arb", arb_req, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_ovf_clr", ovf_err, 0);
        chk("t6_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
